// File: rtl/viterbi_link_ctrl.sv
// Frame sequencer and channel-error scheduler for the Viterbi encoder/decoder link.
// Define VITERBI_CTRL_INJECT_EN to build the periodic channel bit-flip injector.
module viterbi_link_ctrl #(
  parameter int FRAME_BITS  = 32,
  parameter int TAIL_BITS   = 8,
  parameter int ENC_LATENCY = 1,
  parameter int DEC_LATENCY = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [FRAME_BITS-1:0] frame_i,
  input  logic [3:0]            err_period_i,
  input  logic                  decoded_bit_i,
  output logic                  encoder_bit_o,
  output logic                  encoder_en_o,
  output logic [1:0]            inject_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [7:0]            err_count_o,
  output logic [7:0]            inj_count_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SEND  = 3'd1;
  localparam logic [2:0] FLUSH = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int CNT_W = $clog2(FRAME_BITS + TAIL_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_PAY  = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(TAIL_BITS - 1);

  logic [2:0]             state;
  logic [2:0]             next_state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [CNT_W-1:0]       cmp_idx;
  logic [FRAME_BITS-1:0]  shift_reg;
  logic [FRAME_BITS-1:0]  cmp_reg;
  logic [DEC_LATENCY-1:0] pay_pipe;
  logic                   cmp_done;
  logic                   accept;
  logic                   cmp_strobe;
  logic                   last_cmp;
  logic                   all_cmp;

  assign accept        = (state == IDLE) && start_i;
  // A payload mark emerges from the pipe in the cycle its decoded bit is due.
  assign cmp_strobe    = pay_pipe[DEC_LATENCY-1];
  assign last_cmp      = cmp_strobe && (cmp_idx == LAST_PAY);
  assign all_cmp       = cmp_done || last_cmp;
  assign encoder_bit_o = shift_reg[FRAME_BITS-1];

  // Next-state decode for the frame sequencer.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start_i ? SEND : IDLE;
      SEND:    next_state = (bit_cnt == LAST_PAY) ? FLUSH : SEND;
      FLUSH: begin
        if (bit_cnt == LAST_TAIL) begin
          next_state = all_cmp ? DONE : DRAIN;
        end else begin
          next_state = FLUSH;
        end
      end
      DRAIN:   next_state = all_cmp ? DONE : DRAIN;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Sequencer state, serialiser, compare engine and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      cmp_idx      <= '0;
      shift_reg    <= '0;
      cmp_reg      <= '0;
      pay_pipe     <= '0;
      cmp_done     <= 1'b0;
      encoder_en_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_count_o  <= 8'h00;
    end else begin
      state        <= next_state;
      encoder_en_o <= (next_state == SEND) || (next_state == FLUSH);
      busy_o       <= (next_state == SEND) || (next_state == FLUSH) || (next_state == DRAIN);
      done_o       <= (next_state == DONE);
      pay_pipe     <= (pay_pipe << 1) | DEC_LATENCY'(state == SEND);

      if (state != next_state) begin
        bit_cnt <= '0;
      end else if (encoder_en_o) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (accept) begin
        shift_reg <= frame_i;
      end else if (state == SEND) begin
        shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
      end

      if (accept) begin
        cmp_reg     <= frame_i;
        cmp_idx     <= '0;
        cmp_done    <= 1'b0;
        err_count_o <= 8'h00;
      end else if (cmp_strobe) begin
        cmp_reg <= {cmp_reg[FRAME_BITS-2:0], 1'b0};
        cmp_idx <= cmp_idx + CNT_W'(1);
        if (last_cmp) begin
          cmp_done <= 1'b1;
        end
        if ((decoded_bit_i != cmp_reg[FRAME_BITS-1]) && (err_count_o != 8'hFF)) begin
          err_count_o <= err_count_o + 8'd1;
        end
      end
    end
  end

`ifdef VITERBI_CTRL_INJECT_EN
  logic [3:0]             period;
  logic [3:0]             sym_cnt;
  logic [ENC_LATENCY-1:0] inj_pipe;
  logic                   mark;

  assign mark     = encoder_en_o && (period != 4'd0) && (sym_cnt == period - 4'd1);
  assign inject_o = {2{inj_pipe[ENC_LATENCY-1]}};

  // Symbol counter, injection delay line and injected-symbol count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      period      <= 4'd0;
      sym_cnt     <= 4'd0;
      inj_pipe    <= '0;
      inj_count_o <= 8'h00;
    end else begin
      inj_pipe <= (inj_pipe << 1) | ENC_LATENCY'(mark);
      if (accept) begin
        period      <= err_period_i;
        sym_cnt     <= 4'd0;
        inj_count_o <= 8'h00;
      end else if (encoder_en_o && (period != 4'd0)) begin
        sym_cnt <= mark ? 4'd0 : sym_cnt + 4'd1;
        if (mark && (inj_count_o != 8'hFF)) begin
          inj_count_o <= inj_count_o + 8'd1;
        end
      end
    end
  end
`else
  logic unused_period;
  assign unused_period = ^err_period_i;
  assign inject_o      = 2'b00;
  assign inj_count_o   = 8'h00;
`endif

endmodule

// File: tb/tb_viterbi_link_ctrl.sv
// Scoreboard bench for viterbi_link_ctrl: driver pushes expected frame results, monitor checks on done_o.
module tb_viterbi_link_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] frame_i;
  logic [3:0]  err_period_i;
  logic        decoded_bit_i;
  logic        encoder_bit_o;
  logic        encoder_en_o;
  logic [1:0]  inject_o;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  err_count_o;
  logic [7:0]  inj_count_o;

`ifdef VITERBI_CTRL_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  typedef struct {
    string       name;
    int          c0;
    int          err;
    int          inj;
    logic [63:0] inj_map;
    logic [39:0] stream;
  } exp_t;

  exp_t        sb[$];
  int          vectors   = 0;
  int          errors    = 0;
  int          ncyc      = 0;
  int          cur_c0    = -1000;
  logic [31:0] flip_mask = 32'h0000_0000;
  logic [15:0] dec_hist  = 16'h0000;

  viterbi_link_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .frame_i      (frame_i),
    .err_period_i (err_period_i),
    .decoded_bit_i(decoded_bit_i),
    .encoder_bit_o(encoder_bit_o),
    .encoder_en_o (encoder_en_o),
    .inject_o     (inject_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_count_o  (err_count_o),
    .inj_count_o  (inj_count_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ncyc     <= ncyc + 1;
    dec_hist <= {dec_hist[14:0], encoder_bit_o};
  end

  // Decoder model: encoder bit from 16 cycles earlier, payload bits optionally inverted.
  initial begin : decoder_model
    int r;
    decoded_bit_i = 1'b0;
    forever begin
      @(negedge clk);
      r = ncyc - cur_c0;
      if (r >= 17 && r <= 48) decoded_bit_i = dec_hist[15] ^ flip_mask[r-17];
      else                    decoded_bit_i = dec_hist[15];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, " encoder_bit"}, 64'(encoder_bit_o), 64'd0);
    check({name, " encoder_en"},  64'(encoder_en_o),  64'd0);
    check({name, " inject"},      64'(inject_o),      64'd0);
    check({name, " busy"},        64'(busy_o),        64'd0);
    check({name, " done"},        64'(done_o),        64'd0);
    check({name, " err_count"},   64'(err_count_o),   64'd0);
    check({name, " inj_count"},   64'(inj_count_o),   64'd0);
  endtask

  // Monitor: accumulate per-frame observations, compare against the queue head on done_o.
  initial begin : monitor
    int          en_first;
    int          en_last;
    int          busy_n;
    logic [63:0] map;
    logic [39:0] strm;
    en_first = -1; en_last = -1; busy_n = 0; map = '0; strm = '0;
    forever begin
      @(negedge clk);
      if (inject_o != 2'b00 && inject_o != 2'b11) check("inject_shape", 64'(inject_o), 64'h3);
      if (sb.size() > 0) begin
        int   r;
        exp_t e;
        r = ncyc - sb[0].c0;
        if (encoder_en_o) begin
          if (en_first < 0) en_first = r;
          en_last = r;
          strm = {strm[38:0], encoder_bit_o};
        end
        if (inject_o == 2'b11 && r >= 0 && r < 64) map[r] = 1'b1;
        if (busy_o) busy_n++;
        if (done_o) begin
          e = sb.pop_front();
          check({e.name, " done_cycle"}, 64'(r),           64'd49);
          check({e.name, " busy_at_done"}, 64'(busy_o),    64'd0);
          check({e.name, " busy_cycles"}, 64'(busy_n),     64'd48);
          check({e.name, " en_first"},   64'(en_first),    64'd1);
          check({e.name, " en_last"},    64'(en_last),     64'd40);
          check({e.name, " stream"},     64'(strm),        64'(e.stream));
          check({e.name, " err_count"},  64'(err_count_o), 64'(e.err));
          check({e.name, " inj_count"},  64'(inj_count_o), 64'(e.inj));
          check({e.name, " inj_cycles"}, map,              e.inj_map);
          en_first = -1; en_last = -1; busy_n = 0; map = '0; strm = '0;
        end
      end else if (done_o) begin
        check("unexpected_done", 64'(done_o), 64'd0);
      end
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      check({name, " timeout"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic run_frame(input string name, input logic [31:0] frame, input logic [3:0] per,
                           input logic [31:0] flips, input int err, input int inj,
                           input logic [63:0] map, input int pa, input int pb);
    exp_t e;
    @(negedge clk);
    flip_mask    = flips;
    start_i      = 1'b1;
    frame_i      = frame;
    err_period_i = per;
    cur_c0       = ncyc;
    e.name    = name;
    e.c0      = ncyc;
    e.err     = err;
    e.inj     = INJ ? inj : 0;
    e.inj_map = INJ ? map : 64'h0;
    e.stream  = {frame, 8'h00};
    sb.push_back(e);
    for (int r = 1; r <= 55; r++) begin
      @(negedge clk);
      start_i      = (r == pa) || (r == pb);
      frame_i      = ~frame;
      err_period_i = 4'd2;
    end
    start_i = 1'b0;
    wait_drain(name);
    check({name, " idle_after"}, 64'(busy_o), 64'd0);
  endtask

  initial begin : driver
    rst          = 1'b0;
    start_i      = 1'b1;
    frame_i      = 32'hFFFF_FFFF;
    err_period_i = 4'd1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);

    run_frame("clean",    32'hA5A5_0F0F, 4'd0, 32'h0000_0000, 0,  0,  64'h0, -1, -1);
    run_frame("inject8",  32'hA5A5_0F0F, 4'd8, 32'h0000_0000, 0,  5,  64'h0000_0202_0202_0200, -1, -1);
    run_frame("dec_err2", 32'hDEAD_BEEF, 4'd0, 32'h0010_0008, 2,  0,  64'h0, -1, -1);
    run_frame("dec_all",  32'h0000_0000, 4'd1, 32'hFFFF_FFFF, 32, 40, 64'h0000_03FF_FFFF_FFFC, -1, -1);
    run_frame("ign_start", 32'hA5A5_0F0F, 4'd8, 32'h0000_0000, 0, 5,  64'h0000_0202_0202_0200, 5, 49);

    // Abort a frame with reset at cycle 10, then confirm a fresh frame runs cleanly.
    @(negedge clk);
    start_i      = 1'b1;
    frame_i      = 32'hFFFF_FFFF;
    err_period_i = 4'd1;
    flip_mask    = 32'h0000_0000;
    cur_c0       = ncyc;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    check("abort en_before_reset", 64'(encoder_en_o), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check_zero("abort");
    rst = 1'b1;
    run_frame("after_abort", 32'h1234_5678, 4'd3, 32'h0000_0000, 0, 13, 64'h0000_0124_9249_2490, -1, -1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/viterbi_link_ctrl.md
# viterbi_link_ctrl

Frame sequencer and channel-error scheduler for the Viterbi encoder/decoder link. On a start pulse it:
- serialises a parallel frame into the convolutional encoder, followed by zero tail bits to terminate the trellis;
- drives a programmable periodic bit-flip mask to the channel register;
- compares the decoder's output stream against the transmitted frame and reports error and injection counts.

It sits beside the encoder, channel register and decoder, replacing free-running stimulus and error counters.

## Interface
Parameters:
- FRAME_BITS, 32, payload bits per frame (≥2)
- TAIL_BITS, 8, zero flush bits after payload (≥1)
- ENC_LATENCY, 1, cycles from encoder_en_o to the matching encoder symbol at the channel register
- DEC_LATENCY, 16, cycles from encoder_en_o of payload bit i to decoded_bit_i for bit i

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start_i  in  1  frame request pulse
- frame_i  in  FRAME_BITS  payload, sampled on accepted start, sent MSB first
- err_period_i  in  4  injection period in symbols, sampled on accepted start; 0 disables injection
- decoded_bit_i  in  1  decoder output bit
- encoder_bit_o  out  1  serial bit to encoder
- encoder_en_o  out  1  encoder enable
- inject_o  out  2  channel flip mask, XORed onto the 2-bit encoder symbol
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle completion pulse
- err_count_o  out  8  payload bit mismatches, saturating
- inj_count_o  out  8  injected symbols, saturating

## Operation
- FSM states are IDLE, SEND, FLUSH, DRAIN, DONE. Reset forces IDLE, and every output is 0.
- IDLE: start_i=1 is accepted. On acceptance the block loads the frame shift register and latches err_period_i. It clears both counters, the symbol counter, the bit index and the compare index, then goes to SEND.
- SEND: for FRAME_BITS cycles, encoder_en_o=1 and encoder_bit_o = current MSB; the shift register shifts left each cycle. The block then goes to FLUSH.
- FLUSH: for TAIL_BITS cycles, encoder_en_o=1 and encoder_bit_o=0. The block then goes to DRAIN, or straight to DONE if all payload compares are already complete.
- DRAIN: encoder_en_o=0. The block waits until the compare for payload bit FRAME_BITS-1 has executed, then goes to DONE.
- DONE: done_o=1 for one cycle, busy_o=0, then the block returns to IDLE. err_count_o and inj_count_o hold until the next accepted start.
- Injection uses a symbol counter sym_cnt that advances on every encoder_en_o cycle (payload and tail).
  - When period p≠0 and sym_cnt==p-1, the symbol is marked and sym_cnt wraps to 0.
  - The mark is delayed ENC_LATENCY cycles, then presented as inject_o=2'b11 for one cycle. Otherwise inject_o=2'b00.
  - inj_count_o increments on each marked symbol.
  - p=1 injects every symbol. Tail symbols can be injected.
- Comparison: a copy of the frame is held in a compare register. Payload bit i is compared with decoded_bit_i exactly DEC_LATENCY cycles after its encoder_en_o cycle. A mismatch increments err_count_o. Tail-bit decoder outputs are ignored.
- Both counters saturate at 8'hFF.
- start_i is ignored in every state except IDLE. An accepted start never aborts a frame.
- Reset asserted mid-frame: on the next clock the FSM returns to IDLE and every output is 0. Delay lines are cleared.

## Timing
- Start accepted on edge at cycle 0; SEND occupies cycles 1..FRAME_BITS.
- encoder_en_o is high in cycles 1..FRAME_BITS+TAIL_BITS.
- Compare for bit i occurs in cycle 1+DEC_LATENCY+i.
- busy_o is high from cycle 1 to the last cycle of FLUSH/DRAIN. done_o is high in the following cycle.
- inject_o for symbol k (0-based) appears in cycle 1+k+ENC_LATENCY.
- Back-to-back: a start in the DONE cycle is ignored. The earliest new start is accepted in the IDLE cycle after DONE.

## Configuration
- VITERBI_CTRL_INJECT_EN defined: injection logic is as described above.
- VITERBI_CTRL_INJECT_EN undefined:
  - inject_o is tied to 2'b00 and inj_count_o to 8'h00;
  - err_period_i is ignored and the symbol counter and delay line are removed;
  - sequencing and comparison are unchanged.

## Test plan
All scenarios use defaults. The bench's decoder model returns encoder_bit_o delayed 16 cycles unless stated otherwise.
- Reset: hold rst=0 for 3 cycles with start_i=1 -> all outputs 0, busy_o=0.
- Clean frame: frame_i=32'hA5A5_0F0F, err_period_i=0, start at cycle 0.
  - encoder_en_o is high in cycles 1..40.
  - Bit stream is 1010_0101…, then 8 zeros.
  - done_o is high only in cycle 49, with err_count_o=0 and inj_count_o=0.
- Injection: err_period_i=8 -> inject_o=2'b11 only in cycles 9, 17, 25, 33, 41; inj_count_o=5 at done.
- Decoder errors: the model inverts payload bits 3 and 20 -> err_count_o=2. All-inverted decoder output -> err_count_o=32.
- Robustness:
  - start_i pulsed in cycles 5 and 49 -> ignored; counts are unchanged.
  - rst=0 at cycle 10 -> IDLE and outputs 0 at cycle 11; a new start then completes normally.
- Macro undefined, err_period_i=8 -> inject_o stays 0 and inj_count_o=0; done_o is still high in cycle 49.
